// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package rf_pkg;

  localparam int REG_ADDR_W           = 5;
  localparam int NUM_REGS             = 32;
  localparam int XLEN_DEFAULT         = 32;
  localparam int FIFO_DEPTH_DEFAULT   = 2;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  // One buffered writeback from the multi-cycle unit.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   addr;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

  // Register x0 is hardwired to zero and never written.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback-side bus of the arbiter: pipeline result, multi-cycle result
// handshake, issue tracking, hazard outputs and the reg_file write port.
interface rf_wb_arbiter_if #(
  parameter int XLEN = rf_pkg::XLEN_DEFAULT
);
  import rf_pkg::*;

  // Source A: pipeline writeback.
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;
  // Source B: multi-cycle unit results.
  logic                  mc_valid;
  logic                  mc_ready;
  logic [REG_ADDR_W-1:0] mc_addr;
  logic [XLEN-1:0]       mc_data;
  // Issue of a B operation and the resulting hazard state.
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_addr;
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  pipe_stall;
  // reg_file write port.
  logic                  reg_wr;
  logic [REG_ADDR_W-1:0] waddr;
  logic [XLEN-1:0]       wdata;

  // Arbiter side.
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  mc_valid, mc_addr, mc_data,
    input  issue_valid, issue_addr,
    output mc_ready, busy_vec, pipe_stall,
    output reg_wr, waddr, wdata
  );

  // Pipeline / reg_file side.
  modport master (
    output wb_valid, wb_addr, wb_data,
    output mc_valid, mc_addr, mc_data,
    output issue_valid, issue_addr,
    input  mc_ready, busy_vec, pipe_stall,
    input  reg_wr, waddr, wdata
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of writeback entries. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Advance each pointer by one on its own operation; wrap is implicit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; clearing them empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage written on push.
  // NOTE: storage is deliberately left without reset; empty pointers make
  // stale contents unobservable, and a reset here would block RAM mapping.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single reg_file write port between the pipeline writeback
// (fixed priority, never stalled) and buffered multi-cycle results.
// Also tracks registers with outstanding multi-cycle results and raises an
// advisory stall when buffered results are starved of the port.
// XLEN must equal rf_pkg::XLEN_DEFAULT, the width of the buffered entries.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  rf_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  // FIFO hookup.
  wb_entry_t push_entry;
  wb_entry_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      push;
  logic      drain;

  // Write-port mux results.
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;

  // State.
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                pipe_stall_q, pipe_stall_d;

  // Ready depends only on occupancy, never on a same-cycle drain.
  assign bus.mc_ready = !fifo_full;
  // Results for x0 are accepted from B but discarded rather than buffered.
  assign push         = bus.mc_valid && !fifo_full && !is_x0(bus.mc_addr);
  assign push_entry   = '{addr: bus.mc_addr, data: bus.mc_data};

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (drain),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Write-port mux: A always owns the port when valid, else drain the head.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    drain   = 1'b0;
    if (bus.wb_valid) begin
      wr_en   = !is_x0(bus.wb_addr);
      wr_addr = bus.wb_addr;
      wr_data = bus.wb_data;
    end else if (!fifo_empty) begin
      drain   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = fifo_head.addr;
      wr_data = fifo_head.data;
    end
  end

  assign bus.reg_wr = wr_en;
  assign bus.waddr  = wr_addr;
  assign bus.wdata  = wr_data;

  // Busy scoreboard next state: clear on drain, then set on issue so a
  // same-cycle issue to the drained register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (drain) busy_d[fifo_head.addr] = 1'b0;
    if (bus.issue_valid && !is_x0(bus.issue_addr)) busy_d[bus.issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Starvation counter and stall request next state.
  always_comb begin
    if (fifo_empty || drain) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    pipe_stall_d = (starve_cnt_q == CNT_MAX) && !drain;
  end

  // All arbiter state registers.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      starve_cnt_q <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  assign bus.busy_vec   = busy_q;
  assign bus.pipe_stall = pipe_stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random
// traffic, scored against a queue-based behavioural model.
module tb_rf_wb_arbiter;

  localparam int XLEN         = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  rf_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  rf_wb_arbiter #(
    .XLEN         (XLEN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int          cyc;
    logic        ready;
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;
    logic        stall;
  } st_exp_t;

  // Reference model state.
  ent_t        mfifo[$];
  logic [31:0] mbusy;
  int          run;          // consecutive cycles buffered results went unserved

  // Scoreboards.
  wr_exp_t wr_q[$];
  st_exp_t st_q[$];

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  // Model one cycle: predict this cycle's outputs, then advance to the next.
  task automatic model(input bit rst, input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit iv, input logic [4:0] ia);
    st_exp_t s;
    wr_exp_t w;
    ent_t    e;
    bit      drain;
    if (rst) begin
      mfifo.delete();
      mbusy = '0;
      run   = 0;
    end
    s.cyc   = cyc;
    s.ready = (mfifo.size() < FIFO_DEPTH);
    s.busy  = mbusy;
    // Stall shows once results have waited more than the limit.
    s.stall = (run > STARVE_LIMIT);
    drain   = 1'b0;
    if (wv) begin
      s.wr = (wa != 0); s.waddr = wa; s.wdata = wd;
    end else if (mfifo.size() > 0) begin
      drain = 1'b1;
      s.wr = 1'b1; s.waddr = mfifo[0].addr; s.wdata = mfifo[0].data;
    end else begin
      s.wr = 1'b0; s.waddr = '0; s.wdata = '0;
    end
    st_q.push_back(s);
    if (s.wr) begin
      w.cyc = cyc; w.addr = s.waddr; w.data = s.wdata;
      wr_q.push_back(w);
    end
    if (!rst) begin
      if (mfifo.size() > 0 && !drain) run = (run < 1000) ? run + 1 : run;
      else run = 0;
      if (drain) begin
        e = mfifo.pop_front();
        mbusy[e.addr] = 1'b0;
      end
      if (mv && s.ready && ma != 0) begin
        e.addr = ma; e.data = md;
        mfifo.push_back(e);
      end
      if (iv && ia != 0) mbusy[ia] = 1'b1;
    end
  endtask

  task automatic step(input bit rst, input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input bit iv, input logic [4:0] ia);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.wb_valid    = wv;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    bus.mc_valid    = mv;
    bus.mc_addr     = ma;
    bus.mc_data     = md;
    bus.issue_valid = iv;
    bus.issue_addr  = ia;
    cyc++;
    model(rst, wv, wa, wd, mv, ma, md, iv, ia);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare status every cycle and pop a write whenever the DUT writes.
  always @(negedge clk) begin
    st_exp_t s;
    wr_exp_t w;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      check("mc_ready",   bus.mc_ready,   s.ready);
      check("reg_wr",     bus.reg_wr,     s.wr);
      check("waddr",      bus.waddr,      s.waddr);
      check("wdata",      bus.wdata,      s.wdata);
      check("busy_vec",   bus.busy_vec,   s.busy);
      check("pipe_stall", bus.pipe_stall, s.stall);
    end
    if (bus.reg_wr === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write (cycle %0d): got write x%0d=0x%0h expected none",
                 cyc, bus.waddr, bus.wdata);
      end else begin
        w = wr_q.pop_front();
        check("write_cycle", cyc,       w.cyc);
        check("write_addr",  bus.waddr, w.addr);
        check("write_data",  bus.wdata, w.data);
      end
    end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
      w = wr_q.pop_front();
      checks++;
      $display("FAIL missing_write (cycle %0d): got none expected x%0d=0x%0h",
               cyc, w.addr, w.data);
    end
  end

  initial begin
    reset           = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.mc_valid    = 1'b0;
    bus.mc_addr     = '0;
    bus.mc_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    mbusy           = '0;
    run             = 0;

    // Reset, then idle.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Issue x5, B result for x5, drain one cycle after acceptance.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
    idle(2);

    // A holds the port while B fills the FIFO; starvation raises stall.
    step(0, 1, 3, 32'h11, 1, 7, 32'h77, 1, 7);
    step(0, 1, 3, 32'h11, 1, 8, 32'h88, 1, 8);
    step(0, 1, 3, 32'h11, 1, 9, 32'h99, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 3, 32'h11, 0, 0, 0, 0, 0);
    idle(4);

    // x0 from both sources never writes, never buffers, never marks busy.
    step(0, 1, 0, 32'h55, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 32'h66, 0, 0);
    idle(2);

    // Same-cycle drain of x9 and re-issue to x9: busy stays set.
    step(0, 0, 0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 1, 9, 32'h9999, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle(2);

    // Back-to-back B results, drained in order with ready held high.
    step(0, 0, 0, 0, 1, 10, 32'h1, 1, 10);
    step(0, 0, 0, 0, 1, 11, 32'h2, 1, 11);
    step(0, 0, 0, 0, 1, 12, 32'h3, 1, 12);
    idle(3);

    // Fill the FIFO, start draining, then reset mid-drain.
    step(0, 1, 1, 32'hA1, 1, 13, 32'hD13, 1, 13);
    step(0, 1, 1, 32'hA2, 1, 14, 32'hD14, 1, 14);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      bit          rst, wv, mv, iv;
      logic [4:0]  wa, ma, ia;
      logic [31:0] wd, md;
      rst = ($urandom_range(199) == 0);
      wv  = ($urandom_range(99) < 40);
      mv  = ($urandom_range(99) < 50);
      iv  = ($urandom_range(99) < 30);
      wa  = 5'($urandom_range(31));
      ma  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
      ia  = 5'($urandom_range(31));
      wd  = $urandom;
      md  = $urandom;
      step(rst, wv, wa, wd, mv, ma, md, iv, ia);
    end
    idle(6);

    @(negedge clk);
    #1;
    check("writes_outstanding", wr_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (reg_wr/waddr/wdata) between two writeback sources.
  - Source A: pipeline writeback. Fixed highest priority, never back-pressured.
  - Source B: multi-cycle execution unit (mul/div/load-miss). Valid/ready handshake.
- B results wait in a small FIFO. A starvation counter raises an advisory pipeline stall.
- A destination scoreboard marks registers with an outstanding B result so hazard logic can stall readers.
- Sits between the execute/writeback stages and reg_file. Its write-port outputs drive reg_file directly.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 2, B result buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go undrained before pipe_stall asserts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- wb_valid  in  1  A has a result this cycle.
- wb_addr  in  5  A destination register.
- wb_data  in  XLEN  A result.
- mc_valid  in  1  B offers a result.
- mc_ready  out  1  B result accepted when mc_valid && mc_ready.
- mc_addr  in  5  B destination register.
- mc_data  in  XLEN  B result.
- issue_valid  in  1  a B operation is issued this cycle.
- issue_addr  in  5  destination of the issued B operation.
- busy_vec  out  32  bit i=1: register i has an outstanding B result.
- pipe_stall  out  1  advisory request to bubble A.
- reg_wr  out  1  to reg_file write enable.
- waddr  out  5  to reg_file write address.
- wdata  out  XLEN  to reg_file write data.

Behaviour:
- Reset (async): FIFO empty, busy_vec=0, starve_cnt=0, pipe_stall=0.
  - This gives mc_ready=1 and reg_wr=0 while wb_valid=0.
  - Reset mid-operation discards buffered B results and all busy bits.
- Write-port mux (combinational, same cycle):
  - If wb_valid: waddr=wb_addr, wdata=wb_data, reg_wr=(wb_addr!=0).
  - Else if FIFO not empty: drive the head entry, reg_wr=1, and pop the head at posedge ("drain").
  - Else: reg_wr=0, waddr=0, wdata=0.
- Writes to x0 never reach reg_file. A with wb_addr=0 still owns the port that cycle, so B does not drain.
- B acceptance:
  - mc_ready = !full (combinational, independent of mc_valid).
  - An accepted B result with mc_addr!=0 is pushed at posedge.
  - An accepted B result with mc_addr=0 is dropped and not pushed.
  - B latency is at least 1 cycle: a push never drains in the same cycle.
- Simultaneous push and drain on a full FIFO: mc_ready stays 0. Ready does not depend on the drain.
- Scoreboard, per bit i, next-state priority:
  - Set if issue_valid && issue_addr==i && i!=0.
  - Else clear if a B drain writes register i.
  - Else hold.
  - Same-cycle set and clear on one register: set wins.
  - Bit 0 is constant 0.
  - An A write to a busy register leaves the busy bit unchanged.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and not drained, saturating at STARVE_LIMIT.
  - It resets to 0 on any drain or when the FIFO is empty.
  - pipe_stall is registered: it is 1 the cycle after starve_cnt reaches STARVE_LIMIT, and stays 1 until the cycle after a drain.
  - pipe_stall is advisory. A wins the port even while pipe_stall=1.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit or a count.

Decomposition:
- rf_pkg holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - typedef wb_entry_t, a struct of addr[4:0] and data[XLEN-1:0].
  - The FIFO_DEPTH and STARVE_LIMIT defaults.
- Sub-module rf_wb_fifo: a generic synchronous FIFO of wb_entry_t with push/pop/full/empty/head, async active-high reset. It is instantiated once.
- Scoreboard, starvation counter and mux stay in the top module.

Test Plan:
- Reset, then idle: reg_wr=0, mc_ready=1, busy_vec=0, pipe_stall=0. Assert reset mid-drain: the FIFO clears at once.
- Issue to x5, then a B result for x5 (0xDEAD_BEEF) with wb_valid=0: reg_wr=1, waddr=5 and wdata=0xDEADBEEF one cycle after acceptance. busy_vec[5] goes 1→0 on the drain.
- wb_valid held high with wb_addr=3, wb_data=0x11, while B pushes x7 and x8: A writes every cycle and mc_ready=0 after 2 pushes. pipe_stall=1 after 4 undrained cycles. Drop wb_valid: x7 then x8 drain on consecutive cycles, then pipe_stall=0.
- wb_addr=0 with wb_valid=1, and a B result to x0: reg_wr=0 in both cases, the FIFO stays empty, and busy_vec[0] stays 0.
- Same cycle: drain of x9 and issue_valid with issue_addr=9 → busy_vec[9]=1 after the clock.
- Back-to-back B results 0x1, 0x2, 0x3 to x10, x11, x12 with wb idle: in-order writes, and mc_ready never falls.
